// File: rtl/cart_pkg.sv
// Shared types and constants for the MegaROM cartridge mapper.
package cart_pkg;

    typedef enum logic [1:0] {
        ASCII8     = 2'd0,
        ASCII16    = 2'd1,
        KONAMI     = 2'd2,
        KONAMI_SCC = 2'd3
    } mapper_mode_t;

    // Every mapper switches the ROM in 8 KB pages.
    localparam int PAGE_AW = 13;

    // Power-on bank value. Konami carts boot with bank[i] = i so the
    // image appears linearly. ASCII carts boot with everything at page 0.
    function automatic logic [1:0] bank_reset_val(input mapper_mode_t m,
                                                  input logic [1:0]   idx);
        return (m == KONAMI || m == KONAMI_SCC) ? idx : 2'd0;
    endfunction

endpackage

// File: rtl/cart_bank_decode.sv
// Maps the mapper mode and the CPU address window addr[15:11] to a one-hot
// bank register write enable.
module cart_bank_decode
    import cart_pkg::*;
(
    input  mapper_mode_t mode,
    input  logic [4:0]   addr_hi,
    input  logic         wr_en,
    output logic [3:0]   bank_we
);

    // Decode the 2 KB write window that owns each bank register.
    always_comb begin
        bank_we = 4'b0000;
        if (wr_en) begin
            case (mode)
                ASCII8: begin
                    // 0x6000-0x7FFF, one 2 KB window per bank.
                    if (addr_hi[4:2] == 3'b011)
                        bank_we[addr_hi[1:0]] = 1'b1;
                end
                ASCII16: begin
                    if (addr_hi == 5'd12) bank_we[0] = 1'b1;      // 0x6000
                    else if (addr_hi == 5'd14) bank_we[1] = 1'b1; // 0x7000
                end
                KONAMI: begin
                    // bank 0 is hard-wired. The others take a full 8 KB window each.
                    if (addr_hi[4:2] == 3'b011)      bank_we[1] = 1'b1;
                    else if (addr_hi[4:2] == 3'b100) bank_we[2] = 1'b1;
                    else if (addr_hi[4:2] == 3'b101) bank_we[3] = 1'b1;
                end
                KONAMI_SCC: begin
                    case (addr_hi)
                        5'd10:   bank_we[0] = 1'b1;   // 0x5000
                        5'd14:   bank_we[1] = 1'b1;   // 0x7000
                        5'd18:   bank_we[2] = 1'b1;   // 0x9000
                        5'd22:   bank_we[3] = 1'b1;   // 0xB000
                        default: bank_we = 4'b0000;
                    endcase
                end
                default: bank_we = 4'b0000;
            endcase
        end
    end

endmodule

// File: rtl/cart_megarom.sv
// MegaROM mapper: this module holds the bank registers and translates CPU
// addresses into linear ROM byte addresses and battery-SRAM accesses.
module cart_megarom
    import cart_pkg::*;
#(
    parameter int BANK_W  = 8,
    parameter int MEM_AW  = 25,
    parameter int SRAM_AW = 13
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         mode,
    input  logic [MEM_AW-1:0]  rom_size,
    input  logic [15:0]        addr,
    input  logic [7:0]         d_from_cpu,
    input  logic               wr,
    input  logic               cs,
    output logic [MEM_AW-1:0]  mem_addr,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic               sram_we,
    output logic               sram_oe
);

    localparam int BLK_W = MEM_AW - PAGE_AW;

    mapper_mode_t      mode_in;
    mapper_mode_t      mode_q;
    logic [BANK_W-1:0] bank [4];
    logic [BANK_W-1:0] bank_data;
    logic [3:0]        bank_we;
    logic              mode_chg;

    logic [1:0]        slot8;
    logic [BANK_W-1:0] act_bank;
    logic [BANK_W:0]   page;
    logic [BLK_W-1:0]  blk_cnt;
    logic [BLK_W-1:0]  page_mask;
    logic              ascii_mode;
    logic              sram_sel;
    logic              rom_size_lo_unused;

    assign mode_in   = mapper_mode_t'(mode);
    assign mode_chg  = (mode_in != mode_q);
    assign bank_data = BANK_W'(d_from_cpu);

    cart_bank_decode u_decode (
        .mode    (mode_q),
        .addr_hi (addr[15:11]),
        .wr_en   (cs && wr),
        .bank_we (bank_we)
    );

    // Bank register file. A mode change reloads the boot values and drops
    // any write that lands in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mode_q <= mode_in;
            for (int i = 0; i < 4; i++)
                bank[i] <= BANK_W'(bank_reset_val(mode_in, 2'(i)));
        end else if (mode_chg) begin
            mode_q <= mode_in;
            for (int i = 0; i < 4; i++)
                bank[i] <= BANK_W'(bank_reset_val(mode_in, 2'(i)));
        end else begin
            for (int i = 0; i < 4; i++)
                if (bank_we[i]) bank[i] <= bank_data;
        end
    end

    // Choose the active bank and form the 8 KB page index for this address.
    always_comb begin
        // 0x4000->b0, 0x6000->b1, 0x8000->b2, 0xA000->b3. Other areas alias.
        slot8 = addr[14:13] ^ 2'b10;
        if (mode_q == ASCII16) begin
            act_bank = bank[addr[15] ? 2'd1 : 2'd0];
            page     = {act_bank, addr[13]};
        end else begin
            act_bank = bank[slot8];
            page     = {1'b0, act_bank};
        end
    end

    // The ROM image is a power of two in size, so wrapping is a simple mask.
    assign blk_cnt   = rom_size[MEM_AW-1:PAGE_AW];
    assign page_mask = blk_cnt - BLK_W'(1);
    assign mem_addr  = {BLK_W'(page) & page_mask, addr[PAGE_AW-1:0]};

    // A bank value with the "one past the ROM" bit set selects the SRAM.
    // Only the ASCII mappers carry a battery SRAM.
    assign ascii_mode = (mode_q == ASCII8) || (mode_q == ASCII16);
    assign sram_sel   = ascii_mode && (|(BLK_W'(act_bank) & blk_cnt));
    assign sram_oe    = cs && sram_sel;
    assign sram_we    = cs && wr && sram_sel && (addr[15:14] == 2'b10);
    assign sram_addr  = addr[SRAM_AW-1:0];

    // The bits of rom_size below one page are always zero for a valid image.
    assign rom_size_lo_unused = ^rom_size[PAGE_AW-1:0];

endmodule
